// File: rtl/pipelined_barrel_shifter_pkg.sv
// barrel_shift_pkg: mode codes and elaboration helpers for the pipelined barrel shifter.
// Contents: MODE_* encodings for i_mode, clog2, and the level-to-stage mapping.
// Levels are split evenly across stages. Any remainder levels go to the earliest stages.
package barrel_shift_pkg;
  localparam logic [1:0] MODE_SLL = 2'b00;
  localparam logic [1:0] MODE_SRL = 2'b01;
  localparam logic [1:0] MODE_SRA = 2'b10;
  localparam logic [1:0] MODE_ROL = 2'b11;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
    return r;
  endfunction
  function automatic int stage_first(input int s, input int levels, input int stages);
    return s * (levels / stages) + ((s < levels % stages) ? s : levels % stages);
  endfunction
  function automatic int level_stage(input int k, input int levels, input int stages);
    int r;
    r = 0;
    for (int s = 1; s < stages; s++) if (stage_first(s, levels, stages) <= k) r = s;
    return r;
  endfunction
endpackage

// File: rtl/pipelined_barrel_shifter_if.sv
// pipelined_barrel_shifter_if: valid/ready stream bundle for the barrel shifter.
// Input side: i_valid, i_ready, i_bits, i_shift, i_mode. Output side: o_valid, o_ready, o_bits.
// Modports: master = producer/consumer (testbench or datapath), slave = shifter.
interface pipelined_barrel_shifter_if
  import barrel_shift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SW    = clog2(WIDTH)
);
  logic             i_valid;
  logic             i_ready;
  logic [WIDTH-1:0] i_bits;
  logic [SW-1:0]    i_shift;
  logic [1:0]       i_mode;
  logic             o_valid;
  logic             o_ready;
  logic [WIDTH-1:0] o_bits;
  modport master (output i_valid, i_bits, i_shift, i_mode, o_ready, input i_ready, o_valid, o_bits);
  modport slave  (input i_valid, i_bits, i_shift, i_mode, o_ready, output i_ready, o_valid, o_bits);
endinterface

// File: rtl/pipelined_barrel_shifter_level.sv
// barrel_shift_level: one combinational mux level that shifts by AMT when en is set.
// Ports: i_data (in), en (in), mode (in, MODE_*), o_data (out).
// Macro PIPELINED_BARREL_SHIFTER_ROTATE_EN builds the rotate path. Without it, MODE_ROL shifts like SLL.
module barrel_shift_level
  import barrel_shift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int AMT   = 1
) (
  input  logic [WIDTH-1:0] i_data,
  input  logic             en,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] o_data
);
  logic signed [WIDTH-1:0] sra;
  logic        [WIDTH-1:0] rol;
  always_comb begin
    sra = $signed(i_data) >>> AMT;
`ifdef PIPELINED_BARREL_SHIFTER_ROTATE_EN
    rol = (i_data << AMT) | (i_data >> (WIDTH - AMT));
`else
    rol = i_data << AMT;
`endif
    o_data = !en ? i_data
           : mode == MODE_SRL ? i_data >> AMT
           : mode == MODE_SRA ? sra
           : mode == MODE_ROL ? rol
           : i_data << AMT;
  end
endmodule

// File: rtl/pipelined_barrel_shifter.sv
// pipelined_barrel_shifter: multi-mode barrel shifter with a valid/ready stream and PIPE_STAGES register stages.
// Ports: clk, rst (synchronous, active-low), bus (pipelined_barrel_shifter_if.slave).
// Macro PIPELINED_BARREL_SHIFTER_ROTATE_EN makes mode 11 a rotate-left. Otherwise mode 11 acts as SLL.
module pipelined_barrel_shifter
  import barrel_shift_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int PIPE_STAGES = 1
) (
  input logic                       clk,
  input logic                       rst,
  pipelined_barrel_shifter_if.slave bus
);
  localparam int LEVELS = clog2(WIDTH);
  typedef struct packed {
    logic [WIDTH-1:0]  data;
    logic [LEVELS-1:0] shift;
    logic [1:0]        mode;
  } beat_t;
  beat_t                  src       [PIPE_STAGES];
  beat_t                  stage_d   [PIPE_STAGES];
  beat_t                  stage_q   [PIPE_STAGES];
  logic [WIDTH-1:0]       stage_out [PIPE_STAGES];
  logic [WIDTH-1:0]       lvl_in    [LEVELS];
  logic [WIDTH-1:0]       lvl_out   [LEVELS];
  logic [PIPE_STAGES-1:0] up_vld, adv, vld_d, vld_q;
  // A stage may load whenever some stage at or after it is empty, or the consumer takes the last beat.
  // This is the unrolled advance chain, and it squeezes bubbles out while stalled.
  for (genvar s = 0; s < PIPE_STAGES; s++) begin : g_stage
    if (s == 0) begin : g_head
      assign src[s]    = {bus.i_bits, bus.i_shift, bus.i_mode};
      assign up_vld[s] = bus.i_valid;
    end else begin : g_body
      assign src[s]    = stage_q[s-1];
      assign up_vld[s] = vld_q[s-1];
    end
    assign adv[s] = bus.o_ready | ~&vld_q[PIPE_STAGES-1:s];
  end
  // Each level's partial shifts are all less than WIDTH. Amounts >= WIDTH therefore saturate through the cascade:
  // SLL and SRL reach zero, SRA reaches all sign bits, and ROL accumulates i_shift mod WIDTH.
  for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
    localparam int G = level_stage(k, LEVELS, PIPE_STAGES);
    if (k == stage_first(G, LEVELS, PIPE_STAGES)) begin : g_first
      assign lvl_in[k] = src[G].data;
    end else begin : g_chain
      assign lvl_in[k] = lvl_out[k-1];
    end
    if (k == stage_first(G + 1, LEVELS, PIPE_STAGES) - 1) begin : g_last
      assign stage_out[G] = lvl_out[k];
    end
    barrel_shift_level #(.WIDTH(WIDTH), .AMT(1 << k)) u_lvl (
      .i_data (lvl_in[k]),
      .en     (src[G].shift[k]),
      .mode   (src[G].mode),
      .o_data (lvl_out[k])
    );
  end
  always_comb begin
    for (int s = 0; s < PIPE_STAGES; s++)
      stage_d[s] = adv[s] ? {stage_out[s], src[s].shift, src[s].mode} : stage_q[s];
    vld_d = (adv & up_vld) | (~adv & vld_q);
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      vld_q <= '0;
      for (int s = 0; s < PIPE_STAGES; s++) stage_q[s] <= '0;
    end else begin
      vld_q   <= vld_d;
      stage_q <= stage_d;
    end
  end
  assign bus.i_ready = adv[0];
  assign bus.o_valid = vld_q[PIPE_STAGES-1];
  assign bus.o_bits  = stage_q[PIPE_STAGES-1].data;
endmodule
